// File: rtl/sfo_fft_correlator_bank.sv
// rtl/sfo_fft_correlator_bank.sv - harmonic-comb SFO correlator bank over FFT magnitude frames
module sfo_fft_correlator_bank #(
  parameter int FFT_LEN_LOG2       = 9,
  parameter int POWER_WIDTH        = 16,
  parameter int NUM_HYP            = 4,
  parameter int SFO_INT_WIDTH      = 9,
  parameter int SFO_FRAC_WIDTH     = 16,
  parameter int NUM_HARMONICS_LOG2 = 4,
  parameter int SKIRT_WIDTH        = 2,
  parameter int THR_FRAC           = 8,
  localparam int IDX_W = (NUM_HYP > 1) ? $clog2(NUM_HYP) : 1,
  localparam int ACC_W = POWER_WIDTH + FFT_LEN_LOG2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [NUM_HYP*SFO_INT_WIDTH-1:0]    sfo_int_part,
  input  logic [NUM_HYP*SFO_FRAC_WIDTH-1:0]   sfo_frac_part,
  input  logic [NUM_HARMONICS_LOG2-1:0]       num_harmonics,
  input  logic [POWER_WIDTH-1:0]              corr_threshold,
  input  logic [POWER_WIDTH-1:0]              mag_in,
  input  logic                                mag_valid,
  input  logic                                mag_last,
  output logic                                busy,
  output logic                                result_valid,
  input  logic                                result_ready,
  output logic                                result_found,
  output logic [IDX_W-1:0]                    result_idx,
  output logic [ACC_W-1:0]                    result_num,
  output logic [ACC_W-1:0]                    result_den,
  output logic [NUM_HYP-1:0]                  result_pass
);

  // Harmonic positions can run past the frame end; wide enough that they never wrap.
  localparam int POS_W   = ((SFO_INT_WIDTH > FFT_LEN_LOG2) ? SFO_INT_WIDTH : FFT_LEN_LOG2) + NUM_HARMONICS_LOG2 + 2;
  localparam int SINCE_W = $clog2(SKIRT_WIDTH + 1);
  localparam int CMP_W   = ACC_W + THR_FRAC + POWER_WIDTH;
  localparam int PROD_W  = 2 * ACC_W;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SCAN, S_OUT} state_t;
  state_t state, state_nxt;

  logic [FFT_LEN_LOG2-1:0]       bin_idx;
  logic [IDX_W-1:0]              scan_idx;
  logic [NUM_HARMONICS_LOG2-1:0] nh_r;
  logic [POWER_WIDTH-1:0]        thr_r;

  logic [SFO_INT_WIDTH-1:0]      int_r   [NUM_HYP];
  logic [SFO_FRAC_WIDTH-1:0]     frac_r  [NUM_HYP];
  logic [POS_W-1:0]              pos_r   [NUM_HYP];
  logic [SFO_FRAC_WIDTH-1:0]     facc_r  [NUM_HYP];
  logic [ACC_W-1:0]              num_r   [NUM_HYP];
  logic [ACC_W-1:0]              den_r   [NUM_HYP];
  logic [NUM_HARMONICS_LOG2-1:0] hcnt_r  [NUM_HYP];
  logic [SINCE_W-1:0]            since_r [NUM_HYP];

  logic [POS_W-1:0]              pos_init  [NUM_HYP];
  logic [SFO_FRAC_WIDTH-1:0]     facc_init [NUM_HYP];
  logic [NUM_HYP-1:0]            active, hit, skirt;
  logic [ACC_W:0]                num_sum   [NUM_HYP];
  logic [ACC_W:0]                den_sum   [NUM_HYP];
  logic [SFO_FRAC_WIDTH:0]       fsum      [NUM_HYP];
  logic [POS_W-1:0]              pos_step  [NUM_HYP];

  logic [ACC_W-1:0] cur_num, cur_den, cur_den1, best_den1;
  logic [CMP_W-1:0] thr_lhs, thr_rhs;
  logic             pass_cur, better;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: start aborts and restarts from any state
  always_comb begin
    state_nxt = state;
    if (start) state_nxt = S_ACCUM;
    else begin
      case (state)
        S_IDLE:  state_nxt = S_IDLE;
        S_ACCUM: if (mag_valid && (mag_last || (&bin_idx))) state_nxt = S_SCAN;
        S_SCAN:  if (scan_idx == IDX_W'(NUM_HYP - 1)) state_nxt = S_OUT;
        S_OUT:   if (result_ready) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy         = (state != S_IDLE);
    result_valid = (state == S_OUT);
  end

  // Per-hypothesis beat evaluation: harmonic hit, skirt (noise) bin, saturating sums
  always_comb begin
    for (int i = 0; i < NUM_HYP; i++) begin
      pos_init[i]  = POS_W'(sfo_int_part[i*SFO_INT_WIDTH +: SFO_INT_WIDTH])
                   + POS_W'(sfo_frac_part[i*SFO_FRAC_WIDTH + SFO_FRAC_WIDTH - 1]);
      facc_init[i] = sfo_frac_part[i*SFO_FRAC_WIDTH +: SFO_FRAC_WIDTH]
                   + {1'b1, {(SFO_FRAC_WIDTH-1){1'b0}}};
      active[i]    = (hcnt_r[i] < nh_r);
      hit[i]       = (POS_W'(bin_idx) == pos_r[i]);
      skirt[i]     = (bin_idx != '0) && ((POS_W'(bin_idx) + POS_W'(SKIRT_WIDTH)) < pos_r[i])
                   && (since_r[i] >= SINCE_W'(SKIRT_WIDTH));
      num_sum[i]   = {1'b0, num_r[i]} + (ACC_W+1)'(mag_in);
      den_sum[i]   = {1'b0, den_r[i]} + (ACC_W+1)'(mag_in);
      fsum[i]      = {1'b0, facc_r[i]} + {1'b0, frac_r[i]};
      pos_step[i]  = pos_r[i] + POS_W'(int_r[i]) + POS_W'(fsum[i][SFO_FRAC_WIDTH]);
    end
  end

  // Scan comparison: threshold test and cross-multiplied ratio against current best
  always_comb begin
    cur_num   = num_r[scan_idx];
    cur_den   = den_r[scan_idx];
    cur_den1  = (cur_den == '0) ? ACC_W'(1) : cur_den;
    best_den1 = (result_den == '0) ? ACC_W'(1) : result_den;
    thr_lhs   = CMP_W'(cur_num) << THR_FRAC;
    thr_rhs   = CMP_W'(thr_r) * CMP_W'(cur_den1);
    pass_cur  = (thr_lhs > thr_rhs);
    better    = !result_found ||
                ((PROD_W'(cur_num) * PROD_W'(best_den1)) > (PROD_W'(result_num) * PROD_W'(cur_den1)));
  end

  // Datapath: config latch, accumulation per beat, one-hypothesis-per-cycle scan
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_idx      <= '0;
      scan_idx     <= '0;
      nh_r         <= '0;
      thr_r        <= '0;
      result_found <= 1'b0;
      result_idx   <= '0;
      result_num   <= '0;
      result_den   <= '0;
      result_pass  <= '0;
      for (int i = 0; i < NUM_HYP; i++) begin
        int_r[i]   <= '0;
        frac_r[i]  <= '0;
        pos_r[i]   <= '0;
        facc_r[i]  <= '0;
        num_r[i]   <= '0;
        den_r[i]   <= '0;
        hcnt_r[i]  <= '0;
        since_r[i] <= '0;
      end
    end else if (start) begin
      bin_idx      <= '0;
      scan_idx     <= '0;
      nh_r         <= num_harmonics;
      thr_r        <= corr_threshold;
      result_found <= 1'b0;
      result_idx   <= '0;
      result_num   <= '0;
      result_den   <= '0;
      result_pass  <= '0;
      for (int i = 0; i < NUM_HYP; i++) begin
        int_r[i]   <= sfo_int_part[i*SFO_INT_WIDTH +: SFO_INT_WIDTH];
        frac_r[i]  <= sfo_frac_part[i*SFO_FRAC_WIDTH +: SFO_FRAC_WIDTH];
        pos_r[i]   <= pos_init[i];
        facc_r[i]  <= facc_init[i];
        num_r[i]   <= '0;
        den_r[i]   <= '0;
        hcnt_r[i]  <= '0;
        since_r[i] <= SINCE_W'(SKIRT_WIDTH);
      end
    end else if (state == S_ACCUM && mag_valid) begin
      bin_idx <= bin_idx + 1'b1;
      for (int i = 0; i < NUM_HYP; i++) begin
        if (active[i]) begin
          if (hit[i]) begin
            num_r[i]   <= num_sum[i][ACC_W] ? '1 : num_sum[i][ACC_W-1:0];
            hcnt_r[i]  <= hcnt_r[i] + 1'b1;
            since_r[i] <= '0;
            pos_r[i]   <= pos_step[i];
            facc_r[i]  <= fsum[i][SFO_FRAC_WIDTH-1:0];
          end else if (skirt[i]) begin
            den_r[i]   <= den_sum[i][ACC_W] ? '1 : den_sum[i][ACC_W-1:0];
          end else if (since_r[i] < SINCE_W'(SKIRT_WIDTH)) begin
            since_r[i] <= since_r[i] + 1'b1;
          end
        end
      end
    end else if (state == S_SCAN) begin
      scan_idx              <= scan_idx + 1'b1;
      result_pass[scan_idx] <= pass_cur;
      if (pass_cur && better) begin
        result_found <= 1'b1;
        result_idx   <= scan_idx;
        result_num   <= cur_num;
        result_den   <= cur_den;
      end
    end
  end

endmodule

// File: tb/tb_sfo_fft_correlator_bank.sv
// tb/tb_sfo_fft_correlator_bank.sv - directed self-checking bench for sfo_fft_correlator_bank
module tb_sfo_fft_correlator_bank;

  localparam int NH = 4;
  localparam int IW = 9;
  localparam int FW = 16;
  localparam int PW = 16;
  localparam int AW = 25;

  logic              clk;
  logic              reset;
  logic              start;
  logic [NH*IW-1:0]  sfo_int_part;
  logic [NH*FW-1:0]  sfo_frac_part;
  logic [3:0]        num_harmonics;
  logic [PW-1:0]     corr_threshold;
  logic [PW-1:0]     mag_in;
  logic              mag_valid;
  logic              mag_last;
  logic              busy;
  logic              result_valid;
  logic              result_ready;
  logic              result_found;
  logic [1:0]        result_idx;
  logic [AW-1:0]     result_num;
  logic [AW-1:0]     result_den;
  logic [NH-1:0]     result_pass;

  int n_cmp = 0;
  int n_bad = 0;

  sfo_fft_correlator_bank dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .sfo_int_part   (sfo_int_part),
    .sfo_frac_part  (sfo_frac_part),
    .num_harmonics  (num_harmonics),
    .corr_threshold (corr_threshold),
    .mag_in         (mag_in),
    .mag_valid      (mag_valid),
    .mag_last       (mag_last),
    .busy           (busy),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .result_found   (result_found),
    .result_idx     (result_idx),
    .result_num     (result_num),
    .result_den     (result_den),
    .result_pass    (result_pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mag_of(input int mode, input int b);
    case (mode)
      0:       return (b == 8 || b == 16 || b == 24 || b == 32) ? 16'd100 : 16'd1;
      1:       return 16'd1;
      2:       return (b == 9 || b == 17 || b == 26 || b == 34) ? 16'd100 : 16'd1;
      default: return 16'hFFFF;
    endcase
  endfunction

  task automatic do_start(input logic [8:0] i0, input logic [8:0] i1, input logic [8:0] i2,
                          input logic [8:0] i3, input logic [15:0] f3, input logic [3:0] nh,
                          input logic [15:0] thr);
    sfo_int_part   = {i3, i2, i1, i0};
    sfo_frac_part  = {f3, 16'd0, 16'd0, 16'd0};
    num_harmonics  = nh;
    corr_threshold = thr;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sfo_int_part   = '0;
    sfo_frac_part  = '0;
    num_harmonics  = '0;
    corr_threshold = '0;
  endtask

  task automatic send_frame(input int mode, input int n_bins, input bit use_last);
    for (int b = 0; b < n_bins; b++) begin
      mag_in    = mag_of(mode, b);
      mag_valid = 1'b1;
      mag_last  = use_last && (b == n_bins - 1);
      @(posedge clk); #1;
    end
    mag_valid = 1'b0;
    mag_last  = 1'b0;
    mag_in    = '0;
  endtask

  task automatic wait_result(output int lat);
    lat = -1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #1;
      if (result_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic accept(input string name);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    n_cmp++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_accept got valid=%0b busy=%0b want 0/0", name, result_valid, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mag_valid = 1'b0; mag_last = 1'b0; mag_in = '0;
    result_ready = 1'b0; sfo_int_part = '0; sfo_frac_part = '0;
    num_harmonics = '0; corr_threshold = '0;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, result_valid, result_found, result_idx, result_num, result_den, result_pass} !== 59'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got busy=%0b valid=%0b found=%0b idx=%0d num=%0d den=%0d pass=%b want all 0",
               busy, result_valid, result_found, result_idx, result_num, result_den, result_pass);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single_harmonic();
    int lat;
    do_start(9'd8, 9'd0, 9'd0, 9'd8, 16'h8000, 4'd4, 16'd1024);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_busy got %0b want 1", busy);
    end
    send_frame(0, 512, 1'b0);
    wait_result(lat);
    n_cmp++;
    if (lat !== NH) begin
      n_bad++;
      $display("FAIL single_latency got %0d want %0d", lat, NH);
    end
    n_cmp++;
    if ({result_found, result_idx, result_num, result_den, result_pass} !== {1'b1, 2'd0, 25'd400, 25'd14, 4'b0001}) begin
      n_bad++;
      $display("FAIL single_result got found=%0b idx=%0d num=%0d den=%0d pass=%b want 1/0/400/14/0001",
               result_found, result_idx, result_num, result_den, result_pass);
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 10; c++) begin
      mag_valid = 1'b1;
      mag_in    = 16'd500;
      mag_last  = (c == 5);
      @(posedge clk); #1;
      n_cmp++;
      if ({result_valid, busy, result_found, result_idx, result_num, result_den, result_pass} !==
          {1'b1, 1'b1, 1'b1, 2'd0, 25'd400, 25'd14, 4'b0001}) begin
        n_bad++;
        $display("FAIL hold_cycle%0d got valid=%0b found=%0b idx=%0d num=%0d den=%0d pass=%b want 1/1/0/400/14/0001",
                 c, result_valid, result_found, result_idx, result_num, result_den, result_pass);
      end
    end
    mag_valid = 1'b0; mag_last = 1'b0; mag_in = '0;
    accept("hold");
  endtask

  task automatic test_tie();
    int lat;
    do_start(9'd8, 9'd8, 9'd16, 9'd0, 16'd0, 4'd2, 16'd1024);
    send_frame(0, 512, 1'b0);
    wait_result(lat);
    n_cmp++;
    if ({result_found, result_idx, result_num, result_den, result_pass} !== {1'b1, 2'd0, 25'd200, 25'd8, 4'b0011}) begin
      n_bad++;
      $display("FAIL tie_result got found=%0b idx=%0d num=%0d den=%0d pass=%b want 1/0/200/8/0011",
               result_found, result_idx, result_num, result_den, result_pass);
    end
    accept("tie");
  endtask

  task automatic test_frac_spacing();
    int lat;
    do_start(9'd8, 9'd0, 9'd0, 9'd8, 16'h8000, 4'd4, 16'd1024);
    send_frame(2, 40, 1'b1);
    wait_result(lat);
    n_cmp++;
    if (lat !== NH) begin
      n_bad++;
      $display("FAIL frac_latency got %0d want %0d", lat, NH);
    end
    n_cmp++;
    if ({result_found, result_idx, result_num, result_den, result_pass} !== {1'b1, 2'd3, 25'd400, 25'd16, 4'b1000}) begin
      n_bad++;
      $display("FAIL frac_result got found=%0b idx=%0d num=%0d den=%0d pass=%b want 1/3/400/16/1000",
               result_found, result_idx, result_num, result_den, result_pass);
    end
    accept("frac");
  endtask

  task automatic test_no_pass();
    int lat;
    do_start(9'd8, 9'd0, 9'd0, 9'd0, 16'd0, 4'd4, 16'd65535);
    send_frame(1, 512, 1'b0);
    wait_result(lat);
    n_cmp++;
    if (lat !== NH) begin
      n_bad++;
      $display("FAIL nopass_latency got %0d want %0d", lat, NH);
    end
    n_cmp++;
    if ({result_found, result_idx, result_num, result_den, result_pass} !== 57'd0) begin
      n_bad++;
      $display("FAIL nopass_result got found=%0b idx=%0d num=%0d den=%0d pass=%b want all 0",
               result_found, result_idx, result_num, result_den, result_pass);
    end
    accept("nopass");
  endtask

  task automatic test_restart();
    int lat;
    do_start(9'd4, 9'd0, 9'd0, 9'd0, 16'd0, 4'd4, 16'd1024);
    send_frame(0, 101, 1'b0);
    do_start(9'd8, 9'd0, 9'd0, 9'd8, 16'h8000, 4'd4, 16'd1024);
    send_frame(0, 512, 1'b0);
    wait_result(lat);
    n_cmp++;
    if ({lat, result_found, result_idx, result_num, result_den, result_pass} !==
        {NH, 1'b1, 2'd0, 25'd400, 25'd14, 4'b0001}) begin
      n_bad++;
      $display("FAIL restart_result got lat=%0d found=%0b idx=%0d num=%0d den=%0d pass=%b want 4/1/0/400/14/0001",
               lat, result_found, result_idx, result_num, result_den, result_pass);
    end
    accept("restart");
  endtask

  task automatic test_reset_mid();
    int lat;
    do_start(9'd8, 9'd0, 9'd0, 9'd0, 16'd0, 4'd4, 16'd1024);
    send_frame(0, 512, 1'b0);
    wait_result(lat);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, result_valid, result_found, result_idx, result_num, result_den, result_pass} !== 59'd0) begin
      n_bad++;
      $display("FAIL reset_out got busy=%0b valid=%0b found=%0b idx=%0d num=%0d den=%0d pass=%b want all 0",
               busy, result_valid, result_found, result_idx, result_num, result_den, result_pass);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    do_start(9'd8, 9'd0, 9'd0, 9'd0, 16'd0, 4'd4, 16'd1024);
    send_frame(0, 50, 1'b0);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, result_valid, result_found, result_num, result_den} !== 53'd0) begin
      n_bad++;
      $display("FAIL reset_bin50 got busy=%0b valid=%0b found=%0b num=%0d den=%0d want all 0",
               busy, result_valid, result_found, result_num, result_den);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    do_start(9'd8, 9'd0, 9'd0, 9'd8, 16'h8000, 4'd4, 16'd1024);
    send_frame(0, 512, 1'b0);
    wait_result(lat);
    n_cmp++;
    if ({lat, result_found, result_idx, result_num, result_den, result_pass} !==
        {NH, 1'b1, 2'd0, 25'd400, 25'd14, 4'b0001}) begin
      n_bad++;
      $display("FAIL reset_rerun got lat=%0d found=%0b idx=%0d num=%0d den=%0d pass=%b want 4/1/0/400/14/0001",
               lat, result_found, result_idx, result_num, result_den, result_pass);
    end
    accept("reset_rerun");
  endtask

  task automatic test_saturate();
    int lat;
    do_start(9'd1, 9'd0, 9'd0, 9'd0, 16'd0, 4'd15, 16'd1024);
    send_frame(3, 21, 1'b1);
    wait_result(lat);
    n_cmp++;
    if ({result_found, result_idx, result_num, result_den, result_pass} !== {1'b1, 2'd0, 25'd983025, 25'd0, 4'b1111}) begin
      n_bad++;
      $display("FAIL sat_result got found=%0b idx=%0d num=%0d den=%0d pass=%b want 1/0/983025/0/1111",
               result_found, result_idx, result_num, result_den, result_pass);
    end
    accept("sat");
  endtask

  initial begin
    test_reset();
    test_single_harmonic();
    test_backpressure();
    test_tie();
    test_frac_spacing();
    test_no_pass();
    test_restart();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
